audio_fifo_writer: RTL and testbench

Producer side of the audio sample FIFO drained by the Nios II subsystem over its `pio_fifo_*` PIOs. Accepts serial left/right samples from the codec receiver, pairs them into 32-bit stereo words `{left[15:0], right[15:0]}`, optionally decimates, and writes them to the FIFO write port. Samples that arrive while the FIFO is full are dropped and counted, never stalled. Malformed channel sequences are counted as desync errors.

---
 rtl/audio_fifo_pkg.sv | 28 ++
 rtl/audio_fifo_writer_if.sv | 32 +++
 rtl/sat_counter.sv | 30 +++
 rtl/audio_fifo_writer.sv | 166 ++++++++++++++++
 tb/tb_audio_fifo_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module   : audio_fifo_pkg
// Summary  : Shared types and constants for the audio FIFO producer.
// Revision : 1.0 - initial release
//==============================================================================
package audio_fifo_pkg;

    typedef enum logic [0:0] {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } pair_state_t;

    typedef logic signed [15:0] sample16_t;

    localparam int c_WORD_W    = 32;
    localparam int c_LEFT_MSB  = 31;
    localparam int c_LEFT_LSB  = 16;
    localparam int c_RIGHT_MSB = 15;
    localparam int c_RIGHT_LSB = 0;

    localparam int c_SAMPLE_W_MIN = 8;
    localparam int c_SAMPLE_W_MAX = 24;
    localparam int c_DECIM_MIN    = 1;
    localparam int c_DECIM_MAX    = 256;

endpackage : audio_fifo_pkg
`default_nettype wire

// File: rtl/audio_fifo_writer_if.sv
`default_nettype none
//==============================================================================
// Module   : audio_fifo_writer_if
// Summary  : Sample-in / FIFO-write / statistics bundle of audio_fifo_writer.
// Revision : 1.0 - initial release
//==============================================================================
interface audio_fifo_writer_if #(
    parameter int SAMPLE_W = 16,
    parameter int STAT_W   = 16
);
    logic [SAMPLE_W-1:0] smp_data;
    logic                smp_valid;
    logic                smp_left;
    logic [31:0]         fifo_data;
    logic                fifo_wrreq;
    logic                fifo_wrfull;
    logic [STAT_W-1:0]   drop_count;
    logic [STAT_W-1:0]   desync_count;

    // Codec receiver + FIFO model side
    modport master (
        output smp_data, smp_valid, smp_left, fifo_wrfull,
        input  fifo_data, fifo_wrreq, drop_count, desync_count
    );

    // Writer side
    modport slave (
        input  smp_data, smp_valid, smp_left, fifo_wrfull,
        output fifo_data, fifo_wrreq, drop_count, desync_count
    );
endinterface : audio_fifo_writer_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//==============================================================================
// Module   : sat_counter
// Summary  : Up-counter that sticks at all-ones; synchronous clear.
// Revision : 1.0 - initial release
//==============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule : sat_counter
`default_nettype wire

// File: rtl/audio_fifo_writer.sv
`default_nettype none
//==============================================================================
// Module   : audio_fifo_writer
// Summary  : Pairs L/R codec samples into {L,R} words and writes them to the
//            audio FIFO through a one-word hold buffer; drops when full.
// Options  : AUDIO_DECIM_EN - build the 1-of-DECIM pair decimator.
// Revision : 1.0 - initial release
//==============================================================================
module audio_fifo_writer
    import audio_fifo_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DECIM    = 1,
    parameter int STAT_W   = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                enable,
    audio_fifo_writer_if.slave  bus
);

    generate
        if (SAMPLE_W < c_SAMPLE_W_MIN || SAMPLE_W > c_SAMPLE_W_MAX ||
            DECIM < c_DECIM_MIN || DECIM > c_DECIM_MAX) begin : g_bad_param
            $error("audio_fifo_writer: SAMPLE_W or DECIM out of range");
        end
    endgenerate

    pair_state_t           r_state;
    pair_state_t           w_state_nxt;
    sample16_t             w_smp16;
    sample16_t             r_left;
    logic                  w_latch_left;
    logic                  w_pair_done;
    logic                  w_desync;
    logic                  w_select;
    logic                  w_write;
    logic                  w_drop;
    logic [c_WORD_W-1:0]   w_word;
    logic [c_WORD_W-1:0]   r_hold;
    logic                  r_hold_valid;

    // Narrow codecs sign-extend, wide codecs keep the MSBs
    generate
        if (SAMPLE_W < 16) begin : g_sext
            assign w_smp16 = {{(16-SAMPLE_W){bus.smp_data[SAMPLE_W-1]}}, bus.smp_data};
        end else if (SAMPLE_W > 16) begin : g_trunc
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^bus.smp_data[SAMPLE_W-17:0];
            assign w_smp16       = bus.smp_data[SAMPLE_W-1 -: 16];
        end else begin : g_pass
            assign w_smp16 = bus.smp_data;
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= WAIT_L;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_latch_left = 1'b0;
        w_pair_done  = 1'b0;
        w_desync     = 1'b0;
        if (!enable) begin
            w_state_nxt = WAIT_L;
        end else if (bus.smp_valid) begin
            case (r_state)
                WAIT_L: begin
                    if (bus.smp_left) begin
                        w_latch_left = 1'b1;
                        w_state_nxt  = WAIT_R;
                    end else begin
                        w_desync = 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus.smp_left) begin
                        w_latch_left = 1'b1;
                        w_desync     = 1'b1;
                    end else begin
                        w_pair_done = 1'b1;
                        w_state_nxt = WAIT_L;
                    end
                end
                default: w_state_nxt = WAIT_L;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_left <= '0;
        end else if (w_latch_left) begin
            r_left <= w_smp16;
        end
    end

    always_comb begin
        w_word                          = '0;
        w_word[c_LEFT_MSB:c_LEFT_LSB]   = r_left;
        w_word[c_RIGHT_MSB:c_RIGHT_LSB] = w_smp16;
    end

`ifdef AUDIO_DECIM_EN
    localparam int                  c_DCNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_MAX = c_DCNT_W'(DECIM - 1);

    logic [c_DCNT_W-1:0] r_dcnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_dcnt <= '0;
        end else if (!enable) begin
            r_dcnt <= '0;
        end else if (w_pair_done) begin
            r_dcnt <= (r_dcnt == c_DCNT_MAX) ? '0 : r_dcnt + 1'b1;
        end
    end

    assign w_select = w_pair_done && (r_dcnt == '0);
`else
    assign w_select = w_pair_done;
`endif

    assign w_write = r_hold_valid & ~bus.fifo_wrfull;
    assign w_drop  = w_select & r_hold_valid & bus.fifo_wrfull;

    // A word leaving this cycle frees the buffer for a pair arriving now
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_select && (!r_hold_valid || w_write)) begin
            r_hold       <= w_word;
            r_hold_valid <= 1'b1;
        end else if (w_write) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign bus.fifo_data  = r_hold;
    assign bus.fifo_wrreq = w_write;

    sat_counter #(.WIDTH(STAT_W)) u_drop_cnt (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_inc   (w_drop),
        .i_clear (1'b0),
        .o_count (bus.drop_count)
    );

    sat_counter #(.WIDTH(STAT_W)) u_desync_cnt (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_inc   (w_desync),
        .i_clear (1'b0),
        .o_count (bus.desync_count)
    );

endmodule : audio_fifo_writer
`default_nettype wire

// File: tb/tb_audio_fifo_writer.sv
`default_nettype none
//==============================================================================
// Module   : tb_audio_fifo_writer
// Summary  : Self-checking bench for audio_fifo_writer (16/24/12-bit codecs).
// Revision : 1.0 - initial release
//==============================================================================
module tb_audio_fifo_writer;

`ifdef AUDIO_DECIM_EN
    localparam int MD = 4;
`else
    localparam int MD = 1;
`endif

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic reset_reset_n;
    logic enable;
    logic en_aux;

    audio_fifo_writer_if #(.SAMPLE_W(16), .STAT_W(16)) bus   ();
    audio_fifo_writer_if #(.SAMPLE_W(24), .STAT_W(16)) bus24 ();
    audio_fifo_writer_if #(.SAMPLE_W(12), .STAT_W(16)) bus12 ();

    audio_fifo_writer #(.SAMPLE_W(16), .DECIM(4), .STAT_W(16)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .bus(bus.slave));
    audio_fifo_writer #(.SAMPLE_W(24), .DECIM(1), .STAT_W(16)) dut24 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(en_aux), .bus(bus24.slave));
    audio_fifo_writer #(.SAMPLE_W(12), .DECIM(1), .STAT_W(16)) dut12 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(en_aux), .bus(bus12.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: stereo pairs in flight and the one-word buffer
    bit          m_hv;
    bit          m_pend;
    logic [31:0] m_hold;
    logic [15:0] m_left;
    int          m_idx;
    int          m_drop;
    int          m_desync;

    logic [31:0] wlog[$];
    int          wcyc[$];
    logic [31:0] log24[$];
    logic [31:0] log12[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] w;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [31:0] logat(input int i);
        return (i < wlog.size()) ? wlog[i] : 32'hDEADDEAD;
    endfunction

    task automatic model_reset();
        m_hv = 0; m_pend = 0; m_hold = '0; m_left = '0;
        m_idx = 0; m_drop = 0; m_desync = 0;
    endtask

    task automatic cycle(input bit en, input bit v, input bit left,
                         input logic [15:0] d, input bit full);
        bit wr;
        bit loaded;
        @(negedge clk_clk);
        enable          = en;
        bus.smp_valid   = v;
        bus.smp_left    = left;
        bus.smp_data    = d;
        bus.fifo_wrfull = full;
        #1;
        check("fifo_wrreq",   {31'b0, bus.fifo_wrreq}, {31'b0, (m_hv && !full)});
        check("fifo_data",    bus.fifo_data, m_hold);
        check("drop_count",   {16'b0, bus.drop_count}, m_drop);
        check("desync_count", {16'b0, bus.desync_count}, m_desync);
        if (bus.fifo_wrreq) begin
            wlog.push_back(bus.fifo_data);
            wcyc.push_back(cyc);
        end
        wr     = m_hv && !full;
        loaded = 0;
        if (!en) begin
            m_pend = 0;
            m_idx  = 0;
        end else if (v) begin
            if (left) begin
                if (m_pend) m_desync = sat16(m_desync + 1);
                m_pend = 1;
                m_left = d;
            end else if (!m_pend) begin
                m_desync = sat16(m_desync + 1);
            end else begin
                m_pend = 0;
                if (m_idx % MD == 0) begin
                    if (!m_hv || wr) begin
                        m_hold = {m_left, d};
                        m_hv   = 1;
                        loaded = 1;
                    end else begin
                        m_drop = sat16(m_drop + 1);
                    end
                end
                m_idx++;
            end
        end
        if (wr && !loaded) m_hv = 0;
        cyc++;
    endtask

    task automatic idle(input int n, input bit full);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 16'h0, full);
    endtask

    task automatic restart(input bit full);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, full);
    endtask

    task automatic pair(input logic [15:0] l, input logic [15:0] r, input bit full);
        cycle(1'b1, 1'b1, 1'b1, l, full);
        cycle(1'b1, 1'b1, 1'b0, r, full);
    endtask

    always @(negedge clk_clk) begin
        if (bus24.fifo_wrreq) log24.push_back(bus24.fifo_data);
        if (bus12.fifo_wrreq) log12.push_back(bus12.fifo_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int r_cyc;
        bit tog;
        reset_reset_n = 1'b0;
        enable        = 1'b0;
        en_aux        = 1'b1;
        bus.smp_valid = 0; bus.smp_left = 0; bus.smp_data = '0; bus.fifo_wrfull = 0;
        bus24.smp_valid = 0; bus24.smp_left = 0; bus24.smp_data = '0; bus24.fifo_wrfull = 0;
        bus12.smp_valid = 0; bus12.smp_left = 0; bus12.smp_data = '0; bus12.fifo_wrfull = 0;
        model_reset();

        vt[0] = '{16'h0000, 16'hFFFF, 32'h0000FFFF};
        vt[1] = '{16'h8000, 16'h7FFF, 32'h80007FFF};
        vt[2] = '{16'hDEAD, 16'hBEEF, 32'hDEADBEEF};
        vt[3] = '{16'h0001, 16'h0002, 32'h00010002};
        vt[4] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
        vt[5] = '{16'h5A5A, 16'hA5A5, 32'h5A5AA5A5};

        repeat (2) @(negedge clk_clk);
        #1;
        check("rst_wrreq",   {31'b0, bus.fifo_wrreq}, 32'h0);
        check("rst_data",    bus.fifo_data, 32'h0);
        check("rst_drop",    {16'b0, bus.drop_count}, 32'h0);
        check("rst_desync",  {16'b0, bus.desync_count}, 32'h0);
        check("rst_data24",  bus24.fifo_data, 32'h0);
        check("rst_wrreq12", {31'b0, bus12.fifo_wrreq}, 32'h0);
        #1 reset_reset_n = 1'b1;

        // Basic pair and its write latency
        restart(0);
        wlog.delete(); wcyc.delete();
        pair(16'h1234, 16'hABCD, 0);
        r_cyc = cyc - 1;
        idle(3, 0);
        check("basic_count", wlog.size(), 1);
        check("basic_word",  logat(0), 32'h1234ABCD);
        check("basic_when",  (wcyc.size() > 0) ? wcyc[0] : -1, r_cyc + 1);
        check("basic_desync", {16'b0, bus.desync_count}, 32'h0);

        // Back-to-back table of pairs
        restart(0);
        wlog.delete();
        for (int i = 0; i < 6; i++) pair(vt[i].l, vt[i].r, 0);
        idle(3, 0);
        j = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % MD == 0) begin
                check("table_word", logat(j), vt[i].w);
                j++;
            end
        end
        check("table_count", wlog.size(), j);

        // Channel-order errors
        restart(0);
        wlog.delete();
        cycle(1, 1, 0, 16'h0009, 0);
        cycle(1, 1, 1, 16'h0001, 0);
        cycle(1, 1, 1, 16'h0002, 0);
        cycle(1, 1, 0, 16'h0003, 0);
        idle(3, 0);
        check("desync_count2", {16'b0, bus.desync_count}, 32'd2);
        check("desync_nwords", wlog.size(), 1);
        check("desync_word",   logat(0), 32'h00020003);

        // Full FIFO across three pairs
        restart(0);
        wlog.delete();
        pair(16'h1111, 16'h2222, 1);
        restart(1);
        pair(16'h3333, 16'h4444, 1);
        restart(1);
        pair(16'h5555, 16'h6666, 1);
        idle(2, 1);
        check("full_drop",    {16'b0, bus.drop_count}, 32'd2);
        check("full_nowrite", wlog.size(), 0);
        idle(4, 0);
        check("full_release_n", wlog.size(), 1);
        check("full_release_w", logat(0), 32'h11112222);

        // Eight pairs: decimation selects every MD-th
        restart(0);
        wlog.delete();
        for (int k = 0; k < 8; k++) pair(16'h0100 + 16'(k), 16'h0200 + 16'(k), 0);
        idle(3, 0);
        j = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % MD == 0) begin
                check("decim_word", logat(j), {16'h0100 + 16'(k), 16'h0200 + 16'(k)});
                j++;
            end
        end
        check("decim_count", wlog.size(), (MD == 4) ? 2 : 8);
        check("decim_drop",  {16'b0, bus.drop_count}, 32'd2);

        // Enable dropped between L and R
        restart(0);
        wlog.delete();
        cycle(1, 1, 1, 16'h0009, 0);
        cycle(0, 1, 0, 16'h0008, 0);
        pair(16'h0005, 16'h0006, 0);
        idle(3, 0);
        check("en_count",  wlog.size(), 1);
        check("en_word",   logat(0), 32'h00050006);
        check("en_desync", {16'b0, bus.desync_count}, 32'd2);

        // Width rule on 24-bit and 12-bit codecs
        @(negedge clk_clk);
        bus24.smp_valid = 1; bus24.smp_left = 1; bus24.smp_data = 24'h800001;
        bus12.smp_valid = 1; bus12.smp_left = 1; bus12.smp_data = 12'h801;
        @(negedge clk_clk);
        bus24.smp_left = 0; bus24.smp_data = 24'h7FFFFF;
        bus12.smp_left = 0; bus12.smp_data = 12'h7FF;
        @(negedge clk_clk);
        bus24.smp_valid = 0;
        bus12.smp_valid = 0;
        repeat (4) @(negedge clk_clk);
        #1;
        check("w24_count", log24.size(), 1);
        check("w24_word",  (log24.size() > 0) ? log24[0] : 32'hDEADDEAD, 32'h80007FFF);
        check("w12_count", log12.size(), 1);
        check("w12_word",  (log12.size() > 0) ? log12[0] : 32'hDEADDEAD, 32'hF80107FF);

        // Randomized run against the model
        restart(0);
        tog = 1;
        for (int n = 0; n < 3000; n++) begin
            bit en, v, lf, fl;
            en = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 2) != 0);
            lf = tog ^ ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 3) == 0);
            cycle(en, v, lf, 16'($urandom), fl);
            if (v) tog = ~lf;
        end
        idle(4, 0);

        // Asynchronous reset with a word waiting in the buffer
        pair(16'hAAAA, 16'h5555, 1);
        @(negedge clk_clk);
        bus.smp_valid   = 0;
        bus.fifo_wrfull = 0;
        #1;
        check("prerst_wrreq", {31'b0, bus.fifo_wrreq}, 32'h1);
        #1 reset_reset_n = 1'b0;
        #1;
        check("arst_wrreq",  {31'b0, bus.fifo_wrreq}, 32'h0);
        check("arst_data",   bus.fifo_data, 32'h0);
        check("arst_drop",   {16'b0, bus.drop_count}, 32'h0);
        check("arst_desync", {16'b0, bus.desync_count}, 32'h0);
        check("arst_data24", bus24.fifo_data, 32'h0);
        model_reset();
        #1 reset_reset_n = 1'b1;
        wlog.delete();
        idle(4, 0);
        check("arst_lost", wlog.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_audio_fifo_writer
`default_nettype wire
